// File: rtl/cwa_pkg.sv
// -----------------------------------------------------------------------------
// cwa_pkg
// Shared definitions for the clause-weight accumulator:
//   state_e   - evaluation FSM states (IDLE, ACC, DONE)
//   beats()   - number of BUS_W-bit load beats needed to cover one weight row
//   sat_step()- signed +/-1 step that saturates at the WW-bit signed limits
// -----------------------------------------------------------------------------
package cwa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // ceil(clausen*ww / bus_w)
    function automatic int beats(input int clausen, input int ww, input int bus_w);
        return (clausen * ww + bus_w - 1) / bus_w;
    endfunction

    // Step a weight held in the low ww bits (sign-extended into 32 bits) by
    // +1 or -1, clamping at +(2^(ww-1)-1) and -2^(ww-1).
    function automatic logic signed [31:0] sat_step(input logic signed [31:0] w,
                                                    input logic               inc,
                                                    input int                 ww);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (ww - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (ww - 1));
        if (inc) begin
            return (w >= hi) ? hi : w + 32'sd1;
        end
        return (w <= lo) ? lo : w - 32'sd1;
    endfunction

endpackage

// File: rtl/cwa_argmax.sv
// -----------------------------------------------------------------------------
// cwa_argmax
// Combinational binary comparison tree returning the index of the largest of
// N_IN signed SUM_W-bit values. Ties resolve to the lowest index.
// Ports:
//   vals     in  N_IN*SUM_W  packed signed values, entry i at [i*SUM_W +: SUM_W]
//   best_idx out IDXW        index of the maximum
// -----------------------------------------------------------------------------
module cwa_argmax #(
    parameter int N_IN  = 4,
    parameter int SUM_W = 14,
    parameter int IDXW  = $clog2(N_IN) + 1
) (
    input  logic [N_IN*SUM_W-1:0] vals,
    output logic [IDXW-1:0]       best_idx
);

    // Heap-ordered tree: node i has children 2i and 2i+1, leaves start at LEAVES.
    localparam int LEAVES = 1 << $clog2(N_IN);
    localparam int NODES  = 2 * LEAVES;

    logic signed [SUM_W-1:0] node_val [NODES];
    logic [IDXW-1:0]         node_idx [NODES];
    logic                    node_ok  [NODES];

    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            node_val[i] = '0;
            node_idx[i] = '0;
            node_ok[i]  = 1'b0;
        end
        // Leaves past N_IN stay invalid so they never win.
        for (int l = 0; l < N_IN; l++) begin
            node_val[LEAVES + l] = vals[l*SUM_W +: SUM_W];
            node_idx[LEAVES + l] = IDXW'(l);
            node_ok[LEAVES + l]  = 1'b1;
        end
        // Left subtree always holds the lower indices, so >= gives the
        // lowest-index tie-break.
        for (int i = LEAVES - 1; i >= 1; i--) begin
            if (node_ok[2*i] && (!node_ok[2*i+1] || node_val[2*i] >= node_val[2*i+1])) begin
                node_val[i] = node_val[2*i];
                node_idx[i] = node_idx[2*i];
            end else begin
                node_val[i] = node_val[2*i+1];
                node_idx[i] = node_idx[2*i+1];
            end
            node_ok[i] = node_ok[2*i] || node_ok[2*i+1];
        end
        best_idx = node_idx[1];
    end

endmodule

// File: rtl/clause_weight_accumulator.sv
// -----------------------------------------------------------------------------
// clause_weight_accumulator
// Clause-weight store and class-sum engine for the convolutional Tsetlin
// machine. Holds CLASSES x CLAUSEN signed weights, loaded in BUS_W-bit beats
// and nudged by saturating +/-1 updates. On start it walks the active clauses
// one per cycle, adding the weights of firing clauses into one sum per class,
// then strobes done with the argmax class.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load_valid/ready/class/offset/data   weight beat interface
//   upd_valid/ready/class/clause/inc     saturating weight update interface
//   rd_class, rd_clause, rd_weight       registered single-weight read
//   start, clause_out, num_clauses       evaluation request
//   busy, done, class_sum, best_class    evaluation status and result
// -----------------------------------------------------------------------------
module clause_weight_accumulator
    import cwa_pkg::*;
#(
    parameter int  CLAUSEN = 10,
    parameter int  CLASSES = 4,
    parameter int  WW      = 9,
    parameter int  BUS_W   = 256,
    parameter int  SUM_W   = WW + $clog2(CLAUSEN) + 1,
    localparam int CW      = $clog2(CLASSES) + 1,
    localparam int NW      = $clog2(CLAUSEN) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [CW-1:0]            load_class,
    input  logic [7:0]               load_offset,
    input  logic [BUS_W-1:0]         load_data,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [CW-1:0]            upd_class,
    input  logic [NW-1:0]            upd_clause,
    input  logic                     upd_inc,
    input  logic [CW-1:0]            rd_class,
    input  logic [NW-1:0]            rd_clause,
    output logic signed [WW-1:0]     rd_weight,
    input  logic                     start,
    input  logic [CLAUSEN-1:0]       clause_out,
    input  logic [NW-1:0]            num_clauses,
    output logic                     busy,
    output logic                     done,
    output logic [CLASSES*SUM_W-1:0] class_sum,
    output logic [CW-1:0]            best_class
);

    localparam int ROW_W = CLAUSEN * WW;
    localparam int BEATS = beats(CLAUSEN, WW, BUS_W);

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q [CLASSES];
    logic [ROW_W-1:0]        row_d [CLASSES];
    logic signed [SUM_W-1:0] sum_q [CLASSES];
    logic signed [SUM_W-1:0] sum_d [CLASSES];
    logic [CLAUSEN-1:0]      fire_q, fire_d;
    logic [NW-1:0]           n_q, n_d;
    logic [NW-1:0]           idx_q, idx_d;
    logic [NW:0]             idx_nxt;
    logic [CW-1:0]           best_q, best_d;
    logic signed [WW-1:0]    rd_weight_q, rd_weight_d;
    logic signed [WW-1:0]    acc_w;
    logic signed [WW-1:0]    upd_w;
    logic [CLASSES*SUM_W-1:0] sum_flat_d;
    logic [CW-1:0]           argmax_idx;
    logic                    load_fire;
    logic                    upd_fire;
    logic                    unused_load_bits;

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign load_ready = !busy;
    // Load wins a same-cycle collision; the update is simply not accepted.
    assign upd_ready  = !busy && !load_valid;
    assign load_fire  = load_valid && load_ready;
    assign upd_fire   = upd_valid && upd_ready;
    assign rd_weight  = rd_weight_q;
    assign best_class = best_q;

    // Beat bits beyond the end of a row are discarded by design.
    assign unused_load_bits = ^load_data;

    // Weight store write path: beat loads and saturating updates.
    always_comb begin
        upd_w = '0;
        for (int k = 0; k < CLASSES; k++) begin
            row_d[k] = row_q[k];
        end
        for (int k = 0; k < CLASSES; k++) begin
            if (load_fire && load_class == CW'(k)) begin
                // Offsets at or past BEATS match no bit, so the beat is dropped.
                for (int i = 0; i < ROW_W; i++) begin
                    if (load_offset == 8'(i / BUS_W)) begin
                        row_d[k][i] = load_data[i % BUS_W];
                    end
                end
            end
            if (upd_fire && upd_class == CW'(k)) begin
                for (int c = 0; c < CLAUSEN; c++) begin
                    if (upd_clause == NW'(c)) begin
                        upd_w = row_q[k][c*WW +: WW];
                        row_d[k][c*WW +: WW] = WW'(sat_step(32'(upd_w), upd_inc, WW));
                    end
                end
            end
        end
    end

    // Read port: out-of-range addresses return zero.
    always_comb begin
        rd_weight_d = '0;
        for (int k = 0; k < CLASSES; k++) begin
            for (int c = 0; c < CLAUSEN; c++) begin
                if (rd_class == CW'(k) && rd_clause == NW'(c)) begin
                    rd_weight_d = row_q[k][c*WW +: WW];
                end
            end
        end
    end

    // Class sums: cleared on an accepted start, one clause per ACC cycle.
    // The idx < n guard makes the single ACC cycle for N=0 add nothing.
    always_comb begin
        acc_w = '0;
        for (int k = 0; k < CLASSES; k++) begin
            sum_d[k] = sum_q[k];
        end
        if (state_q == IDLE && start) begin
            for (int k = 0; k < CLASSES; k++) begin
                sum_d[k] = '0;
            end
        end else if (state_q == ACC && idx_q < n_q) begin
            for (int k = 0; k < CLASSES; k++) begin
                for (int c = 0; c < CLAUSEN; c++) begin
                    if (idx_q == NW'(c) && fire_q[c]) begin
                        acc_w    = row_q[k][c*WW +: WW];
                        sum_d[k] = sum_q[k] + SUM_W'(acc_w);
                    end
                end
            end
        end
    end

    always_comb begin
        sum_flat_d = '0;
        class_sum  = '0;
        for (int k = 0; k < CLASSES; k++) begin
            sum_flat_d[k*SUM_W +: SUM_W] = sum_d[k];
            class_sum[k*SUM_W +: SUM_W]  = sum_q[k];
        end
    end

    // Argmax looks at the sums being written this cycle, so the value captured
    // on the ACC->DONE transition reflects the final clause.
    cwa_argmax #(
        .N_IN  (CLASSES),
        .SUM_W (SUM_W),
        .IDXW  (CW)
    ) u_argmax (
        .vals     (sum_flat_d),
        .best_idx (argmax_idx)
    );

    // Evaluation FSM.
    always_comb begin
        state_d = state_q;
        fire_d  = fire_q;
        n_d     = n_q;
        idx_d   = idx_q;
        best_d  = best_q;
        idx_nxt = {1'b0, idx_q} + (NW+1)'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    fire_d  = clause_out;
                    n_d     = (num_clauses > NW'(CLAUSEN)) ? NW'(CLAUSEN) : num_clauses;
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                idx_d = idx_nxt[NW-1:0];
                // Last cycle once idx+1 reaches N; N=0 also exits after one cycle.
                if ({1'b0, n_q} <= idx_nxt) begin
                    best_d  = argmax_idx;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fire_q      <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            best_q      <= '0;
            rd_weight_q <= '0;
            for (int k = 0; k < CLASSES; k++) begin
                row_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fire_q      <= fire_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            rd_weight_q <= rd_weight_d;
            for (int k = 0; k < CLASSES; k++) begin
                row_q[k] <= row_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

endmodule

// File: tb/tb_clause_weight_accumulator.sv
// -----------------------------------------------------------------------------
// tb_clause_weight_accumulator
// Self-checking bench: a behavioural model (weight table as an int array,
// evaluation predicted as a start/finish cycle window with sums computed by
// plain summation) is compared against the DUT every cycle, alongside a few
// literal expectations from hand-worked cases.
// -----------------------------------------------------------------------------
module tb_clause_weight_accumulator;

    localparam int CLAUSEN = 10;
    localparam int CLASSES = 4;
    localparam int WW      = 9;
    localparam int BUS_W   = 256;
    localparam int SUM_W   = WW + $clog2(CLAUSEN) + 1;
    localparam int CW      = $clog2(CLASSES) + 1;
    localparam int NW      = $clog2(CLAUSEN) + 1;
    localparam int WMAX    = 255;
    localparam int WMIN    = -256;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     load_valid;
    logic                     load_ready;
    logic [CW-1:0]            load_class;
    logic [7:0]               load_offset;
    logic [BUS_W-1:0]         load_data;
    logic                     upd_valid;
    logic                     upd_ready;
    logic [CW-1:0]            upd_class;
    logic [NW-1:0]            upd_clause;
    logic                     upd_inc;
    logic [CW-1:0]            rd_class;
    logic [NW-1:0]            rd_clause;
    logic signed [WW-1:0]     rd_weight;
    logic                     start;
    logic [CLAUSEN-1:0]       clause_out;
    logic [NW-1:0]            num_clauses;
    logic                     busy;
    logic                     done;
    logic [CLASSES*SUM_W-1:0] class_sum;
    logic [CW-1:0]            best_class;

    clause_weight_accumulator #(
        .CLAUSEN (CLAUSEN),
        .CLASSES (CLASSES),
        .WW      (WW),
        .BUS_W   (BUS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_class  (load_class),
        .load_offset (load_offset),
        .load_data   (load_data),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_class   (upd_class),
        .upd_clause  (upd_clause),
        .upd_inc     (upd_inc),
        .rd_class    (rd_class),
        .rd_clause   (rd_clause),
        .rd_weight   (rd_weight),
        .start       (start),
        .clause_out  (clause_out),
        .num_clauses (num_clauses),
        .busy        (busy),
        .done        (done),
        .class_sum   (class_sum),
        .best_class  (best_class)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_sum(input int k);
        logic signed [SUM_W-1:0] s;
        s = class_sum[k*SUM_W +: SUM_W];
        return int'(s);
    endfunction

    // ---------------- behavioural model ----------------
    int mw [CLASSES][CLAUSEN];
    int m_sum [CLASSES];
    int m_best     = 0;
    int m_rd       = 0;
    int edge_no    = 0;
    int start_edge = -1;
    int done_edge  = -2;
    bit model_live = 1'b0;

    // The DUT is busy in the cycles following edges start_edge..done_edge,
    // and done_edge's following cycle is the done strobe.
    always @(posedge clk) begin
        bit busy_before;
        int n;
        logic signed [WW-1:0] f;
        if (rst) begin
            for (int k = 0; k < CLASSES; k++) begin
                m_sum[k] = 0;
                for (int c = 0; c < CLAUSEN; c++) mw[k][c] = 0;
            end
            m_best     = 0;
            m_rd       = 0;
            start_edge = -1;
            done_edge  = -2;
            model_live = 1'b1;
        end else if (model_live) begin
            busy_before = (edge_no - 1 >= start_edge) && (edge_no - 1 <= done_edge);
            m_rd = (int'(rd_class) < CLASSES && int'(rd_clause) < CLAUSEN) ?
                   mw[rd_class][rd_clause] : 0;
            if (!busy_before) begin
                if (load_valid) begin
                    // A whole row fits in beat 0 for these parameters.
                    if (int'(load_class) < CLASSES && load_offset == 8'd0) begin
                        for (int c = 0; c < CLAUSEN; c++) begin
                            f = load_data[c*WW +: WW];
                            mw[load_class][c] = int'(f);
                        end
                    end
                end else if (upd_valid) begin
                    if (int'(upd_class) < CLASSES && int'(upd_clause) < CLAUSEN) begin
                        if (upd_inc)
                            mw[upd_class][upd_clause] = (mw[upd_class][upd_clause] + 1 > WMAX) ?
                                                        WMAX : mw[upd_class][upd_clause] + 1;
                        else
                            mw[upd_class][upd_clause] = (mw[upd_class][upd_clause] - 1 < WMIN) ?
                                                        WMIN : mw[upd_class][upd_clause] - 1;
                    end
                end
                if (start) begin
                    n = (int'(num_clauses) > CLAUSEN) ? CLAUSEN : int'(num_clauses);
                    start_edge = edge_no;
                    done_edge  = edge_no + ((n > 0) ? n : 1);
                    for (int k = 0; k < CLASSES; k++) begin
                        m_sum[k] = 0;
                        for (int c = 0; c < n; c++)
                            if (clause_out[c]) m_sum[k] += mw[k][c];
                    end
                    m_best = 0;
                    for (int k = 1; k < CLASSES; k++)
                        if (m_sum[k] > m_sum[m_best]) m_best = k;
                end
            end
        end
        edge_no++;
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        int  x;
        bit  eb;
        bit  ed;
        if (model_live) begin
            x  = edge_no - 1;
            eb = (x >= start_edge) && (x <= done_edge);
            ed = (x == done_edge);
            check("busy", int'(busy), int'(eb));
            check("done", int'(done), int'(ed));
            check("load_ready", int'(load_ready), int'(!eb));
            check("upd_ready", int'(upd_ready), int'(!eb && !load_valid));
            check("rd_weight", int'(rd_weight), m_rd);
            if (!eb || ed) begin
                for (int k = 0; k < CLASSES; k++)
                    check($sformatf("class_sum[%0d]", k), dut_sum(k), m_sum[k]);
                check("best_class", int'(best_class), m_best);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [BUS_W-1:0] pack_lin(input int base, input int step);
        logic [BUS_W-1:0] d;
        d = '0;
        for (int c = 0; c < CLAUSEN; c++) d[c*WW +: WW] = WW'(base + step * c);
        return d;
    endfunction

    function automatic logic [BUS_W-1:0] rand_bus();
        logic [BUS_W-1:0] d;
        for (int j = 0; j < BUS_W / 32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic load_row(input int k, input int off, input logic [BUS_W-1:0] d);
        load_valid  = 1'b1;
        load_class  = CW'(k);
        load_offset = 8'(off);
        load_data   = d;
        tick();
        load_valid  = 1'b0;
    endtask

    task automatic upd(input int k, input int c, input bit inc);
        upd_valid  = 1'b1;
        upd_class  = CW'(k);
        upd_clause = NW'(c);
        upd_inc    = inc;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic rd(input int k, input int c, output int v);
        rd_class  = CW'(k);
        rd_clause = NW'(c);
        tick();
        v = int'(rd_weight);
    endtask

    // Returns the cycle count from the start cycle to the done cycle.
    task automatic run_eval(input logic [CLAUSEN-1:0] co, input int n, output int lat);
        clause_out  = co;
        num_clauses = NW'(n);
        start       = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int v;
        int lat;
        int ndone;
        logic [BUS_W-1:0] d;

        rst = 1'b1; load_valid = 0; load_class = '0; load_offset = '0; load_data = '0;
        upd_valid = 0; upd_class = '0; upd_clause = '0; upd_inc = 0;
        rd_class = '0; rd_clause = '0; start = 0; clause_out = '0; num_clauses = '0;
        tick(2);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_best", int'(best_class), 0);
        check("reset_rd", int'(rd_weight), 0);
        for (int k = 0; k < CLASSES; k++) check("reset_sum", dut_sum(k), 0);
        rst = 1'b0;

        // Row k clause c = k*10+c; beat 1 is out of range and dropped.
        for (int k = 0; k < CLASSES; k++) begin
            load_row(k, 0, pack_lin(k * 10, 1));
            load_row(k, 1, rand_bus());
        end
        rd(2, 7, v);
        check("rd_c2_k7", v, 27);
        check("model_c2_k7", mw[2][7], 27);
        rd(3, 9, v);
        check("rd_c3_k9", v, 39);
        rd(5, 1, v);
        check("rd_out_of_range", v, 0);

        // All weights 1, alternating clauses fire.
        for (int k = 0; k < CLASSES; k++) load_row(k, 0, pack_lin(1, 0));
        run_eval(10'b1010101010, 10, lat);
        check("lat_n10", lat, 11);
        for (int k = 0; k < CLASSES; k++) check("sum_alt", dut_sum(k), 5);
        check("best_tie", int'(best_class), 0);
        tick();

        // Class 3 dominates.
        for (int k = 0; k < CLASSES; k++) load_row(k, 0, pack_lin((k == 3) ? 100 : -5, 0));
        run_eval('1, 4, lat);
        check("lat_n4", lat, 5);
        check("sum0_n4", dut_sum(0), -20);
        check("sum3_n4", dut_sum(3), 400);
        check("model_sum3", m_sum[3], 400);
        check("best_n4", int'(best_class), 3);
        tick();
        run_eval('1, 0, lat);
        check("lat_n0", lat, 2);
        for (int k = 0; k < CLASSES; k++) check("sum_n0", dut_sum(k), 0);
        check("best_n0", int'(best_class), 0);
        tick();

        // Saturation.
        d = '0;
        d[0 +: WW]  = 9'd255;
        d[WW +: WW] = 9'h100;
        load_row(0, 0, d);
        repeat (3) upd(0, 0, 1'b1);
        rd(0, 0, v);
        check("sat_hi", v, 255);
        upd(0, 1, 1'b0);
        rd(0, 1, v);
        check("sat_lo", v, -256);
        upd(0, 2, 1'b1);
        upd(0, 2, 1'b0);
        rd(0, 2, v);
        check("inc_dec", v, 0);

        // Load and update in the same cycle: load wins, update retried.
        load_valid = 1'b1; load_class = CW'(1); load_offset = 8'd0; load_data = pack_lin(7, 0);
        upd_valid = 1'b1; upd_class = CW'(0); upd_clause = NW'(3); upd_inc = 1'b1;
        #1;
        check("collide_upd_ready", int'(upd_ready), 0);
        tick();
        load_valid = 1'b0;
        #1;
        check("retry_upd_ready", int'(upd_ready), 1);
        tick();
        upd_valid = 1'b0;
        rd(1, 0, v);
        check("collide_load", v, 7);
        rd(0, 3, v);
        check("retry_upd", v, 1);

        // Start while busy is ignored; loads are blocked during ACC.
        clause_out = '1; num_clauses = NW'(10); start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        check("acc_load_ready", int'(load_ready), 0);
        num_clauses = NW'(1); start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            tick();
        end
        check("single_done", ndone, 1);

        // Reset mid-evaluation.
        clause_out = '1; num_clauses = NW'(10); start = 1'b1;
        tick();
        start = 1'b0;
        tick(3);
        rst = 1'b1;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        rd(2, 7, v);
        check("rst_weights", v, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            load_valid  = ($urandom_range(0, 99) < 15);
            load_class  = CW'($urandom_range(0, 5));
            load_offset = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'd0;
            load_data   = ($urandom_range(0, 9) == 0) ?
                          pack_lin(($urandom_range(0, 1) == 1) ? WMAX : WMIN, 0) : rand_bus();
            upd_valid   = ($urandom_range(0, 2) == 0);
            upd_class   = CW'($urandom_range(0, 4));
            upd_clause  = NW'($urandom_range(0, 11));
            upd_inc     = 1'($urandom_range(0, 1));
            rd_class    = CW'($urandom_range(0, 4));
            rd_clause   = NW'($urandom_range(0, 11));
            start       = ($urandom_range(0, 9) == 0);
            clause_out  = CLAUSEN'($urandom);
            num_clauses = NW'($urandom_range(0, 12));
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end
        load_valid = 0; upd_valid = 0; start = 0; rst = 0;
        tick(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
